vga_mem_arbiter: RTL and testbench

Arbitrates the single-port, synchronous-read frame-buffer memory between the VGA display fetch path and a CPU requester. It takes `hCount`/`vCount`/`bright` from the VGA timing controller and guarantees the display one fetch slot in every 4 pixel clocks. It serialises each fetched 16-bit word into 4-bit pixels for the colour generator. All remaining port cycles are granted to the CPU through a req/ack handshake.

---
 rtl/vga_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_vga_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Frame-buffer port arbiter: VGA fetch slots every 4 pixel clocks always win, the CPU gets the
// remaining cycles through req/ack, and fetched words are shifted out as pixels, MSB nibble first.
module vga_mem_arbiter #(
  parameter int ADDR_W         = 17,
  parameter int FB_BASE        = 0,
  parameter int WORDS_PER_LINE = 160,
  parameter int HVID           = 640,
  parameter int HMAX           = 785,
  parameter int VVID           = 480,
  parameter int VTOTAL         = 525,
  parameter int PREFETCH_H     = 776
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic              bright,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        pixel
);

  // CPU states: IDLE waits for grant | ISSUED address at memory | RETURN data back | ACK pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUED, S_RETURN, S_ACK} cpu_state_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_e;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] WPL  = ADDR_W'(WORDS_PER_LINE);

  cpu_state_e        state_q;
  tag_e              tag0_q, tag1_q;
  logic [ADDR_W-1:0] line_base_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [15:0]       mem_wdata_q;
  logic              cpu_ack_q;
  logic              cpu_rd_q;
  logic [15:0]       cpu_rdata_q;
  logic [15:0]       disp_word_q;
  logic [15:0]       shift_q;

  logic              disp_slot, pre_slot, slot, grant, line_end, shift_load;
  logic [ADDR_W-1:0] slot_addr;

  always_comb begin
    disp_slot  = (vCount < 10'(VVID)) && (hCount[1:0] == 2'd0) && (hCount <= 10'(HVID - 8));
    pre_slot   = (hCount == 10'(PREFETCH_H)) &&
                 ((vCount < 10'(VVID - 1)) || (vCount == 10'(VTOTAL - 1)));
    slot       = disp_slot || pre_slot;
    line_end   = (hCount == 10'(HMAX - 1));
    shift_load = ((hCount[1:0] == 2'd3) && (hCount < 10'(HVID - 1))) || line_end;
    grant      = (state_q == S_IDLE) && cpu_req && !slot;
    // word 0 of each line comes from the prefetch, so display slots run one word ahead
    if (pre_slot)
      slot_addr = (vCount == 10'(VTOTAL - 1)) ? BASE : line_base_q + WPL;
    else
      slot_addr = line_base_q + ADDR_W'(hCount[9:2]) + ADDR_W'(1);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= S_IDLE;
      tag0_q      <= TAG_NONE;
      tag1_q      <= TAG_NONE;
      line_base_q <= BASE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
      disp_word_q <= '0;
      shift_q     <= '0;
    end else begin
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      tag0_q    <= TAG_NONE;
      tag1_q    <= tag0_q;

      if (slot) begin
        mem_addr_q <= slot_addr;
        tag0_q     <= TAG_DISP;
      end else if (grant) begin
        mem_addr_q  <= cpu_addr;
        mem_we_q    <= cpu_we;
        mem_wdata_q <= cpu_wdata;
        cpu_rd_q    <= !cpu_we;
        tag0_q      <= TAG_CPU;
      end

      if (tag1_q == TAG_DISP)
        disp_word_q <= mem_rdata;
      if ((tag1_q == TAG_CPU) && cpu_rd_q)
        cpu_rdata_q <= mem_rdata;

      case (state_q)
        S_IDLE:   if (grant) state_q <= S_ISSUED;
        S_ISSUED: state_q <= S_RETURN;
        S_RETURN: begin
          state_q   <= S_ACK;
          cpu_ack_q <= 1'b1;
        end
        default:  state_q <= S_IDLE;
      endcase

      if (line_end) begin
        if (vCount == 10'(VTOTAL - 1))
          line_base_q <= BASE;
        else if (vCount < 10'(VVID - 1))
          line_base_q <= line_base_q + WPL;
      end

      if (shift_load)
        shift_q <= disp_word_q;
      else
        shift_q <= {shift_q[11:0], 4'h0};
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign pixel     = shift_q[15:12] & {4{bright}};

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: drives hCount/vCount directly, models the frame-buffer memory and
// checks fetch addresses, CPU handshake timing and pixel output against arithmetic expectations.
module tb_vga_mem_arbiter;
  localparam int ADDR_W = 17;
  localparam int FB_BASE = 0;
  localparam int WPL = 160;
  localparam int HVID = 640;
  localparam int HMAX = 785;
  localparam int VVID = 480;
  localparam int VTOTAL = 525;
  localparam int PRE_H = 776;

  logic              clock = 1'b0;
  logic              clear;
  logic [9:0]        hCount, vCount;
  logic              bright;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [15:0]       mem_wdata, mem_rdata;
  logic [3:0]        pixel;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  int errors = 0;
  int checks = 0;

  vga_mem_arbiter #(
    .ADDR_W(ADDR_W), .FB_BASE(FB_BASE), .WORDS_PER_LINE(WPL), .HVID(HVID), .HMAX(HMAX),
    .VVID(VVID), .VTOTAL(VTOTAL), .PREFETCH_H(PRE_H)
  ) dut (
    .clock(clock), .clear(clear), .hCount(hCount), .vCount(vCount), .bright(bright),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel(pixel)
  );

  always #20 clock = ~clock;

  // synchronous-read single-port memory
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic [15:0] pat(int i);
    return 16'((i * 40503) ^ (i >> 5) ^ 16'h3C96);
  endfunction

  function automatic bit ref_slot(int h, int v);
    return (v < VVID && (h % 4) == 0 && h <= HVID - 8) ||
           (h == PRE_H && (v < VVID - 1 || v == VTOTAL - 1));
  endfunction

  function automatic int ref_addr(int h, int v);
    if (h == PRE_H) return (v == VTOTAL - 1) ? FB_BASE : FB_BASE + (v + 1) * WPL;
    return FB_BASE + v * WPL + h / 4 + 1;
  endfunction

  function automatic logic [3:0] ref_pix(int h, int v);
    logic [15:0] w;
    logic [15:0] s;
    w = mem[FB_BASE + v * WPL + h / 4];
    s = w >> (4 * (3 - (h % 4)));
    return s[3:0];
  endfunction

  task automatic set_hv(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = (h < HVID) && (v < VVID);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic adv();
    int h;
    int v;
    h = int'(hCount) + 1;
    v = int'(vCount);
    if (h == HMAX) begin
      h = 0;
      v = (v == VTOTAL - 1) ? 0 : v + 1;
    end
    set_hv(h, v);
  endtask

  task automatic test_reset();
    int k;
    bit seen;
    clear = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    set_hv(700, 500);
    tick(); tick();
    checks++;
    if ({mem_addr, mem_we, mem_wdata, cpu_ack, cpu_rdata, pixel} !== '0) begin
      errors++;
      $display("FAIL reset_state addr=%h we=%b wd=%h ack=%b rd=%h pix=%h required all zero",
               mem_addr, mem_we, mem_wdata, cpu_ack, cpu_rdata, pixel);
    end
    clear = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h0ABCD;
    tick(); adv();
    checks++;
    if (mem_addr !== 17'h0ABCD) begin
      errors++; $display("FAIL reset_pre_grant addr=%h required 0abcd", mem_addr);
    end
    tick(); adv();
    #5 clear = 1'b1;
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_wdata, cpu_ack, cpu_rdata, pixel} !== '0) begin
      errors++;
      $display("FAIL reset_async addr=%h we=%b wd=%h ack=%b rd=%h pix=%h required all zero",
               mem_addr, mem_we, mem_wdata, cpu_ack, cpu_rdata, pixel);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); adv();
      if (cpu_ack) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_no_ack ack pulsed during clear, required none"); end
    clear = 1'b0;
    k = 0;
    seen = 0;
    while (!seen && k < 5) begin
      tick(); k++;
      if (cpu_ack) begin
        seen = 1;
        checks++;
        if (cpu_rdata !== mem[17'h0ABCD]) begin
          errors++; $display("FAIL reset_reissue_data got=%h required %h", cpu_rdata, mem[17'h0ABCD]);
        end
        cpu_req = 1'b0;
      end
      adv();
    end
    checks++;
    if (!seen || k != 3) begin
      errors++; $display("FAIL reset_reissue_latency ack_seen=%0d after %0d clocks, required 3", seen, k);
    end
    tick(); adv(); tick(); adv();
  endtask

  task automatic test_disp_addr();
    int n;
    cpu_req = 1'b0;
    set_hv(PRE_H, VTOTAL - 1); tick();
    checks++;
    if (mem_addr !== 17'd0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL disp_prefetch_frame addr=%0d we=%b required 0/0", mem_addr, mem_we);
    end
    adv();
    n = 0;
    while (!(hCount == 0 && vCount == 0) && n < 20) begin tick(); adv(); n++; end
    tick();
    checks++;
    if (mem_addr !== 17'd1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL disp_v0_h0 addr=%0d we=%b required 1/0", mem_addr, mem_we);
    end
    set_hv(1, 0); tick();
    checks++;
    if (mem_addr !== 17'd1) begin errors++; $display("FAIL disp_nonslot addr=%0d required 1", mem_addr); end
    set_hv(632, 0); tick();
    checks++;
    if (mem_addr !== 17'd159) begin errors++; $display("FAIL disp_h632 addr=%0d required 159", mem_addr); end
    set_hv(636, 0); tick();
    checks++;
    if (mem_addr !== 17'd159) begin errors++; $display("FAIL disp_h636 addr=%0d required 159", mem_addr); end
    set_hv(PRE_H, 0); tick();
    checks++;
    if (mem_addr !== 17'd160) begin errors++; $display("FAIL disp_prefetch_v0 addr=%0d required 160", mem_addr); end
    set_hv(HMAX - 1, 0); tick();
    set_hv(0, 1); tick();
    checks++;
    if (mem_addr !== 17'd161) begin errors++; $display("FAIL disp_v1_h0 addr=%0d required 161", mem_addr); end
    set_hv(PRE_H, VVID - 1); tick();
    checks++;
    if (mem_addr !== 17'd161) begin errors++; $display("FAIL disp_v479_prefetch addr=%0d required 161", mem_addr); end
    set_hv(0, VVID); tick();
    checks++;
    if (mem_addr !== 17'd161) begin errors++; $display("FAIL disp_v480 addr=%0d required 161", mem_addr); end
  endtask

  task automatic test_collision();
    int we_cnt, ack_cnt, ack_h;
    cpu_req = 1'b0;
    we_cnt = 0; ack_cnt = 0; ack_h = -1;
    set_hv(0, 10);
    for (int i = 0; i < 4; i++) begin tick(); adv(); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00100; cpu_wdata = 16'hBEEF;
    for (int h = 4; h < 16; h++) begin
      tick();
      if (mem_we) we_cnt++;
      if (h == 4) begin
        checks++;
        if (mem_we !== 1'b0 || mem_addr === 17'h00100) begin
          errors++; $display("FAIL coll_slot_edge addr=%h we=%b required display fetch, no write", mem_addr, mem_we);
        end
      end
      if (h == 5) begin
        checks++;
        if (mem_addr !== 17'h00100 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF) begin
          errors++; $display("FAIL coll_grant addr=%h we=%b wd=%h required 00100/1/beef", mem_addr, mem_we, mem_wdata);
        end
      end
      if (cpu_ack) begin
        ack_cnt++; ack_h = h; cpu_req = 1'b0;
      end
      adv();
    end
    checks++;
    if (we_cnt != 1) begin errors++; $display("FAIL coll_we_cycles got=%0d required 1", we_cnt); end
    checks++;
    if (ack_cnt != 1 || ack_h != 7) begin
      errors++; $display("FAIL coll_ack count=%0d at h=%0d required 1 at h=7", ack_cnt, ack_h);
    end
    checks++;
    if (mem[17'h00100] !== 16'hBEEF) begin
      errors++; $display("FAIL coll_mem_written got=%h required beef", mem[17'h00100]);
    end
  endtask

  task automatic test_cpu_read_blank();
    int ack1, ack2;
    mem[17'h00200] = 16'h1234;
    mem[17'h00201] = 16'h4321;
    ack1 = -1; ack2 = -1;
    set_hv(100, 500);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00200;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        checks++;
        if (mem_addr !== 17'h00200 || mem_we !== 1'b0) begin
          errors++; $display("FAIL rd_grant addr=%h we=%b required 00200/0", mem_addr, mem_we);
        end
      end
      if (c == 4) begin
        checks++;
        if (mem_addr !== 17'h00201) begin errors++; $display("FAIL rd_b2b_grant addr=%h required 00201", mem_addr); end
      end
      if (cpu_ack) begin
        checks++;
        if (ack1 < 0) begin
          ack1 = c;
          if (cpu_rdata !== 16'h1234) begin errors++; $display("FAIL rd_data1 got=%h required 1234", cpu_rdata); end
          cpu_addr = 17'h00201;
        end else begin
          ack2 = c;
          if (cpu_rdata !== 16'h4321) begin errors++; $display("FAIL rd_data2 got=%h required 4321", cpu_rdata); end
          cpu_req = 1'b0;
        end
      end
      adv();
    end
    checks++;
    if (ack1 != 2 || ack2 != 6) begin
      errors++; $display("FAIL rd_ack_timing ack1=%0d ack2=%0d required 2 and 6", ack1, ack2);
    end
    checks++;
    if (cpu_rdata !== 16'h4321) begin errors++; $display("FAIL rd_data_held got=%h required 4321", cpu_rdata); end
  endtask

  task automatic test_pixel_order();
    logic [15:0] word;
    logic [15:0] sh;
    int n;
    word = 16'hA5C3;
    mem[FB_BASE] = word;
    cpu_req = 1'b0;
    set_hv(770, VTOTAL - 1);
    n = 0;
    while (!(vCount == 0 && hCount == 8) && n < 40) begin
      if (vCount == 0 && hCount >= 4) bright = 1'b0;
      #1;
      checks++;
      if (vCount == 0 && hCount < 4) begin
        sh = word >> (4 * (3 - int'(hCount)));
        if (pixel !== sh[3:0]) begin
          errors++; $display("FAIL pix_order h=%0d got=%h required %h", hCount, pixel, sh[3:0]);
        end
      end else if (pixel !== 4'h0) begin
        errors++; $display("FAIL pix_dark h=%0d v=%0d got=%h required 0", hCount, vCount, pixel);
      end
      tick(); adv(); n++;
    end
  endtask

  task automatic test_stress();
    int c, last_g, grants, acks, limit;
    int h, v, ea;
    bit slot, grant, rd_pend;
    logic [15:0] exp_rd;
    logic [15:0] refm [int];
    c = 0; last_g = -100; grants = 0; acks = 0; rd_pend = 0; exp_rd = '0;
    limit = 5 * HMAX - 20;
    cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = 17'(32'h13000 + $urandom_range(0, 15)); cpu_wdata = 16'($urandom);
    set_hv(0, VTOTAL - 1);
    while (c < 5 * HMAX) begin
      h = int'(hCount); v = int'(vCount);
      #1;
      checks++;
      if (pixel !== (bright ? ref_pix(h, v) : 4'h0)) begin
        errors++; $display("FAIL st_pixel h=%0d v=%0d got=%h required %h", h, v, pixel, bright ? ref_pix(h, v) : 4'h0);
      end
      slot = ref_slot(h, v);
      ea = slot ? ref_addr(h, v) : 0;
      grant = cpu_req && !slot && (c >= last_g + 4);
      tick();
      if (slot) begin
        checks++;
        if (mem_addr !== 17'(ea)) begin
          errors++; $display("FAIL st_disp_addr h=%0d v=%0d got=%0d required %0d", h, v, mem_addr, ea);
        end
      end
      if (grant) begin
        checks++;
        if (mem_addr !== cpu_addr) begin
          errors++; $display("FAIL st_grant h=%0d v=%0d addr=%h required %h", h, v, mem_addr, cpu_addr);
        end
        last_g = c; grants++;
        rd_pend = !cpu_we;
        if (cpu_we) refm[int'(cpu_addr)] = cpu_wdata;
        else exp_rd = refm.exists(int'(cpu_addr)) ? refm[int'(cpu_addr)] : pat(int'(cpu_addr));
      end
      checks++;
      if (mem_we !== (grant && cpu_we)) begin
        errors++; $display("FAIL st_we h=%0d v=%0d got=%b required %b", h, v, mem_we, grant && cpu_we);
      end
      checks++;
      if (cpu_ack !== (c == last_g + 2)) begin
        errors++; $display("FAIL st_ack h=%0d v=%0d got=%b required %b", h, v, cpu_ack, c == last_g + 2);
      end
      if (cpu_ack) begin
        acks++;
        if (rd_pend) begin
          checks++;
          if (cpu_rdata !== exp_rd) begin
            errors++; $display("FAIL st_rdata got=%h required %h", cpu_rdata, exp_rd);
          end
        end
        if (c < limit) begin
          cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 17'(32'h13000 + $urandom_range(0, 15));
          cpu_wdata = 16'($urandom);
        end else begin
          cpu_req = 1'b0;
        end
      end
      adv(); c++;
    end
    checks++;
    if (grants != acks || grants < 100) begin
      errors++; $display("FAIL st_ack_count grants=%0d acks=%0d required equal and at least 100", grants, acks);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pat(i);
    clear = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    set_hv(700, 500);
    test_reset();
    test_disp_addr();
    test_collision();
    test_cpu_read_blank();
    test_pixel_order();
    test_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
